ioctl_rom_loader: RTL and testbench

- Parametrised successor to the top-level ioctl→SDRAM write path. It accepts the HPS byte stream and packs bytes into WORD_BYTES-wide words with per-lane write selects.
- Words are buffered in a small FIFO and drained to one SDRAM port using a toggle req/ack handshake.
- Backpressure to hps_io is raised through ioctl_wait.
- Handles non-contiguous addresses, partial trailing words and end-of-download flush, and reports completion.

---
 rtl/ioctl_loader_pkg.sv | 27 ++
 rtl/ioctl_rom_loader_sync_fifo.sv | 70 +++++++
 rtl/ioctl_rom_loader.sv | 254 +++++++++++++++++++++++++
 tb/tb_ioctl_rom_loader.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ioctl_loader_pkg.sv
// Shared definitions for the ioctl ROM loader: width helpers and drain states.
package ioctl_loader_pkg;

   // Ceiling log2 for elaboration-time sizing (returns 0 for values <= 1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   // Number of byte-address bits that select a lane inside one SDRAM word.
   function automatic int lb_of(input int word_bytes);
      return clog2(word_bytes);
   endfunction

   // Drain handshake states.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } drain_state_e;

endpackage

// File: rtl/ioctl_rom_loader_sync_fifo.sv
// Small synchronous FIFO: registered storage and pointers, fall-through head,
// extra pointer MSB to tell full from empty.
module sync_fifo
   import ioctl_loader_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = clog2(DEPTH),
   localparam int PW    = AW + 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [PW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   always_comb begin
      do_push_s = push_i && (!full_o || pop_i);
      do_pop_s  = pop_i && !empty_o;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents need no reset because the pointers gate visibility.
   always_ff @(posedge clk_i) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din_i;
      end
   end

endmodule

// File: rtl/ioctl_rom_loader.sv
// ioctl byte stream -> SDRAM word writer: packs bytes into lane-masked words,
// buffers them, and drains them through a toggle req/ack handshake.
module ioctl_rom_loader
   import ioctl_loader_pkg::*;
#(
   parameter  int ADDR_W     = 25,
   parameter  int WORD_BYTES = 2,
   parameter  int FIFO_DEPTH = 4,
   parameter  int ROM_INDEX  = 0,
   localparam int LB         = lb_of(WORD_BYTES),
   localparam int WA_W       = ADDR_W - LB,
   localparam int DW         = 8 * WORD_BYTES
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  ioctl_download,
   input  logic [7:0]            ioctl_index,
   input  logic                  ioctl_wr,
   input  logic [ADDR_W-1:0]     ioctl_addr,
   input  logic [7:0]            ioctl_dout,
   output logic                  ioctl_wait,
   output logic [WA_W-1:0]       sdr_addr,
   output logic [DW-1:0]         sdr_din,
   output logic [WORD_BYTES-1:0] sdr_wr_sel,
   output logic                  sdr_req,
   input  logic                  sdr_ack,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);

   localparam int LBW = (LB == 0) ? 1 : LB;
   localparam int PW  = clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [WA_W-1:0]       addr;
      logic [DW-1:0]         data;
      logic [WORD_BYTES-1:0] sel;
   } fifo_entry_t;

   localparam int EW = $bits(fifo_entry_t);

   // Assembly register and download tracking.
   logic                  dl_q;
   logic                  asm_valid_q, asm_valid_d;
   logic [WA_W-1:0]       asm_addr_q, asm_addr_d;
   logic [DW-1:0]         asm_data_q, asm_data_d;
   logic [WORD_BYTES-1:0] asm_mask_q, asm_mask_d;
   logic                  flush_pending_q, flush_pending_d;
   logic                  dl_end_q, dl_end_d;
   logic                  overflow_q, overflow_d;
   logic                  done_q, done_d;

   // Drain side.
   drain_state_e          state_q, state_d;
   logic                  sdr_req_q, sdr_req_d;
   logic [WA_W-1:0]       sdr_addr_q, sdr_addr_d;
   logic [DW-1:0]         sdr_din_q, sdr_din_d;
   logic [WORD_BYTES-1:0] sdr_sel_q, sdr_sel_d;

   // Combinational helpers.
   logic                  acc_s, same_s, rise_s, fall_s, busy_s;
   logic [LBW-1:0]        lane_s;
   logic [WA_W-1:0]       waddr_s;
   logic [DW-1:0]         merged_data_s;
   logic [WORD_BYTES-1:0] merged_mask_s;
   logic                  push_s, pop_s, fifo_room_s;
   fifo_entry_t           push_entry_s, head_s;
   logic [EW-1:0]         head_bits_s;
   logic                  fifo_empty_s, fifo_full_s;
   logic [PW-1:0]         fifo_count_s;

   assign acc_s   = ioctl_wr && ioctl_download && (ioctl_index == 8'(ROM_INDEX));
   assign lane_s  = (WORD_BYTES == 1) ? '0 : ioctl_addr[LBW-1:0];
   assign waddr_s = ioctl_addr[ADDR_W-1:LB];
   assign same_s  = asm_valid_q && (waddr_s == asm_addr_q);
   assign rise_s  = ioctl_download && !dl_q;
   assign fall_s  = !ioctl_download && dl_q;
   assign busy_s  = asm_valid_q || !fifo_empty_s || (state_q == WAIT);
   assign head_s  = fifo_entry_t'(head_bits_s);
   assign fifo_room_s = !fifo_full_s || pop_s;

   // One push of headroom is kept so the word a single byte may complete always fits.
   assign ioctl_wait = (fifo_count_s >= PW'(FIFO_DEPTH - 1)) || flush_pending_q;

   assign sdr_addr   = sdr_addr_q;
   assign sdr_din    = sdr_din_q;
   assign sdr_wr_sel = sdr_sel_q;
   assign sdr_req    = sdr_req_q;
   assign busy       = busy_s;
   assign done       = done_q;
   assign overflow   = overflow_q;

   // Byte assembly: merge the byte into its lane, push on address change, full mask or flush.
   always_comb begin
      asm_valid_d     = asm_valid_q;
      asm_addr_d      = asm_addr_q;
      asm_data_d      = asm_data_q;
      asm_mask_d      = asm_mask_q;
      flush_pending_d = flush_pending_q;
      push_s          = 1'b0;
      push_entry_s    = '0;
      merged_data_s   = same_s ? asm_data_q : '0;
      merged_mask_s   = same_s ? asm_mask_q : '0;
      merged_data_s[8*int'(lane_s) +: 8] = ioctl_dout;
      merged_mask_s[lane_s]              = 1'b1;

      if (flush_pending_q) begin
         // Wait for a free slot so the trailing partial word is never dropped.
         if (fifo_room_s) begin
            push_s          = 1'b1;
            push_entry_s    = '{addr: asm_addr_q, data: asm_data_q, sel: asm_mask_q};
            asm_valid_d     = 1'b0;
            asm_data_d      = '0;
            asm_mask_d      = '0;
            flush_pending_d = 1'b0;
         end else begin
            flush_pending_d = 1'b1;
         end
      end else if (acc_s) begin
         if (asm_valid_q && !same_s) begin
            // Byte belongs to another word: retire the held one, start afresh.
            push_s       = 1'b1;
            push_entry_s = '{addr: asm_addr_q, data: asm_data_q, sel: asm_mask_q};
            asm_valid_d  = 1'b1;
            asm_addr_d   = waddr_s;
            asm_data_d   = merged_data_s;
            asm_mask_d   = merged_mask_s;
         end else if (&merged_mask_s) begin
            push_s       = 1'b1;
            push_entry_s = '{addr: waddr_s, data: merged_data_s, sel: merged_mask_s};
            asm_valid_d  = 1'b0;
            asm_data_d   = '0;
            asm_mask_d   = '0;
         end else begin
            asm_valid_d  = 1'b1;
            asm_addr_d   = waddr_s;
            asm_data_d   = merged_data_s;
            asm_mask_d   = merged_mask_s;
         end
      end else if (fall_s && asm_valid_q) begin
         flush_pending_d = 1'b1;
      end else begin
         flush_pending_d = flush_pending_q;
      end
   end

   // Download bookkeeping: sticky overflow and the single completion pulse.
   always_comb begin
      overflow_d = rise_s ? 1'b0 : overflow_q;
      dl_end_d   = dl_end_q;
      done_d     = 1'b0;
      if (push_s && !fifo_room_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_d;
      end
      if (rise_s) begin
         dl_end_d = 1'b0;
      end else if (fall_s) begin
         dl_end_d = 1'b1;
      end else if (dl_end_q && !ioctl_download && !busy_s && !flush_pending_q) begin
         done_d   = 1'b1;
         dl_end_d = 1'b0;
      end else begin
         dl_end_d = dl_end_q;
      end
   end

   // Drain FSM: present the FIFO head, toggle req, pop once ack catches up.
   always_comb begin
      state_d    = state_q;
      sdr_req_d  = sdr_req_q;
      sdr_addr_d = sdr_addr_q;
      sdr_din_d  = sdr_din_q;
      sdr_sel_d  = sdr_sel_q;
      pop_s      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty_s) begin
               sdr_addr_d = head_s.addr;
               sdr_din_d  = head_s.data;
               sdr_sel_d  = head_s.sel;
               sdr_req_d  = ~sdr_req_q;
               state_d    = WAIT;
            end else begin
               state_d    = IDLE;
            end
         end
         WAIT: begin
            if (sdr_ack == sdr_req_q) begin
               pop_s   = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = WAIT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset abandons any pending handshake by matching req to ack.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         dl_q            <= 1'b0;
         asm_valid_q     <= 1'b0;
         asm_addr_q      <= '0;
         asm_data_q      <= '0;
         asm_mask_q      <= '0;
         flush_pending_q <= 1'b0;
         dl_end_q        <= 1'b0;
         overflow_q      <= 1'b0;
         done_q          <= 1'b0;
         state_q         <= IDLE;
         sdr_req_q       <= sdr_ack;
         sdr_addr_q      <= '0;
         sdr_din_q       <= '0;
         sdr_sel_q       <= '0;
      end else begin
         dl_q            <= ioctl_download;
         asm_valid_q     <= asm_valid_d;
         asm_addr_q      <= asm_addr_d;
         asm_data_q      <= asm_data_d;
         asm_mask_q      <= asm_mask_d;
         flush_pending_q <= flush_pending_d;
         dl_end_q        <= dl_end_d;
         overflow_q      <= overflow_d;
         done_q          <= done_d;
         state_q         <= state_d;
         sdr_req_q       <= sdr_req_d;
         sdr_addr_q      <= sdr_addr_d;
         sdr_din_q       <= sdr_din_d;
         sdr_sel_q       <= sdr_sel_d;
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_sys),
      .reset_i (reset),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .din_i   (push_entry_s),
      .dout_o  (head_bits_s),
      .empty_o (fifo_empty_s),
      .full_o  (fifo_full_s),
      .count_o (fifo_count_s)
   );

endmodule

// File: tb/tb_ioctl_rom_loader.sv
// Directed bench: default loader (A) plus a 4-byte-word, 2-deep loader (B).
module tb_ioctl_rom_loader;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // DUT A (defaults)
   logic        a_download, a_wr, a_wait, a_req, a_ack, a_busy, a_done, a_ovf;
   logic [7:0]  a_index, a_dout;
   logic [24:0] a_addr;
   logic [23:0] a_sdr_addr;
   logic [15:0] a_sdr_din;
   logic [1:0]  a_sel;
   // DUT B (WORD_BYTES=4, FIFO_DEPTH=2)
   logic        b_download, b_wr, b_wait, b_req, b_ack, b_busy, b_done, b_ovf;
   logic [7:0]  b_index, b_dout;
   logic [24:0] b_addr;
   logic [22:0] b_sdr_addr;
   logic [31:0] b_sdr_din;
   logic [3:0]  b_sel;

   bit a_ack_en, b_ack_en;
   int done_cnt_a = 0, done_cnt_b = 0;
   int passed = 0, total = 0;
   logic [31:0] la_addr[$], la_din[$], la_sel[$];
   logic [31:0] lb_addr[$], lb_din[$], lb_sel[$];

   ioctl_rom_loader u_a (
      .clk_sys(clk), .reset(rst), .ioctl_download(a_download), .ioctl_index(a_index),
      .ioctl_wr(a_wr), .ioctl_addr(a_addr), .ioctl_dout(a_dout), .ioctl_wait(a_wait),
      .sdr_addr(a_sdr_addr), .sdr_din(a_sdr_din), .sdr_wr_sel(a_sel), .sdr_req(a_req),
      .sdr_ack(a_ack), .busy(a_busy), .done(a_done), .overflow(a_ovf));

   ioctl_rom_loader #(.ADDR_W(25), .WORD_BYTES(4), .FIFO_DEPTH(2), .ROM_INDEX(0)) u_b (
      .clk_sys(clk), .reset(rst), .ioctl_download(b_download), .ioctl_index(b_index),
      .ioctl_wr(b_wr), .ioctl_addr(b_addr), .ioctl_dout(b_dout), .ioctl_wait(b_wait),
      .sdr_addr(b_sdr_addr), .sdr_din(b_sdr_din), .sdr_wr_sel(b_sel), .sdr_req(b_req),
      .sdr_ack(b_ack), .busy(b_busy), .done(b_done), .overflow(b_ovf));

   // SDRAM responders: ack three cycles after a new request when enabled.
   initial begin
      int cnt;
      cnt = 0;
      a_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (a_ack_en && a_req != a_ack) begin
            if (cnt >= 2) begin a_ack = a_req; cnt = 0; end
            else cnt++;
         end else cnt = 0;
      end
   end
   initial begin
      int cnt;
      cnt = 0;
      b_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (b_ack_en && b_req != b_ack) begin
            if (cnt >= 2) begin b_ack = b_req; cnt = 0; end
            else cnt++;
         end else cnt = 0;
      end
   end

   // Request loggers: a request is a req change that leaves req != ack.
   initial begin
      logic last;
      last = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && a_req != last && a_req != a_ack) begin
            la_addr.push_back(32'(a_sdr_addr));
            la_din.push_back(32'(a_sdr_din));
            la_sel.push_back(32'(a_sel));
         end
         if (a_done) done_cnt_a++;
         last = a_req;
      end
   end
   initial begin
      logic last;
      last = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && b_req != last && b_req != b_ack) begin
            lb_addr.push_back(32'(b_sdr_addr));
            lb_din.push_back(32'(b_sdr_din));
            lb_sel.push_back(32'(b_sel));
         end
         if (b_done) done_cnt_b++;
         last = b_req;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-cycle byte strobe to DUT A (which=0) or B (which=1), optionally obeying ioctl_wait.
   task automatic send_byte(input bit which, input logic [24:0] a, input logic [7:0] d, input bit honor);
      int guard;
      guard = 0;
      if (honor) begin
         while ((which ? b_wait : a_wait) && guard < 200) begin
            cycles(1);
            guard++;
         end
         if (guard >= 200) begin
            total++;
            $display("FAIL wait_bound: ioctl_wait still high after %0d cycles, required low", guard);
         end
      end
      if (which) begin b_addr = a; b_dout = d; b_wr = 1'b1; end
      else begin a_addr = a; a_dout = d; a_wr = 1'b1; end
      cycles(1);
      a_wr = 1'b0;
      b_wr = 1'b0;
   endtask

   typedef struct {
      logic [24:0] a0; logic [7:0] d0;
      logic [24:0] a1; logic [7:0] d1;
      logic [31:0] e_addr; logic [31:0] e_din; logic [31:0] e_sel;
   } vec_t;

   initial begin
      vec_t vt[4];
      int   base, dstart;
      logic [7:0] lo, hi;

      vt[0] = '{25'd0, 8'h11, 25'd1, 8'h12, 32'd0, 32'h1211, 32'h3};
      vt[1] = '{25'd2, 8'h13, 25'd3, 8'h14, 32'd1, 32'h1413, 32'h3};
      vt[2] = '{25'd4, 8'h15, 25'd5, 8'h16, 32'd2, 32'h1615, 32'h3};
      vt[3] = '{25'd6, 8'h17, 25'd7, 8'h18, 32'd3, 32'h1817, 32'h3};

      rst = 1'b1;
      a_download = 1'b0; a_index = 8'd0; a_wr = 1'b0; a_addr = '0; a_dout = 8'd0;
      b_download = 1'b0; b_index = 8'd0; b_wr = 1'b0; b_addr = '0; b_dout = 8'd0;
      a_ack_en = 1'b1; b_ack_en = 1'b1;
      cycles(3);
      rst = 1'b0;
      cycles(1);

      // Reset state
      check("rst_wait", 32'(a_wait), 32'd0);
      check("rst_busy", 32'(a_busy), 32'd0);
      check("rst_done", 32'(a_done), 32'd0);
      check("rst_ovf", 32'(a_ovf), 32'd0);
      check("rst_sel", 32'(a_sel), 32'd0);
      check("rst_addr", 32'(a_sdr_addr), 32'd0);
      check("rst_din", 32'(a_sdr_din), 32'd0);
      check("rst_req_eq_ack", 32'(a_req), 32'(a_ack));
      check("rst_b_busy", 32'(b_busy), 32'd0);

      // Contiguous load from the vector table
      base = la_addr.size(); dstart = done_cnt_a;
      a_download = 1'b1;
      cycles(1);
      for (int i = 0; i < 4; i++) begin
         send_byte(1'b0, vt[i].a0, vt[i].d0, 1'b1);
         send_byte(1'b0, vt[i].a1, vt[i].d1, 1'b1);
      end
      a_download = 1'b0;
      cycles(60);
      check("s1_nreq", 32'(la_addr.size() - base), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (base + i < la_addr.size()) begin
            check($sformatf("s1_addr%0d", i), la_addr[base+i], vt[i].e_addr);
            check($sformatf("s1_din%0d", i), la_din[base+i], vt[i].e_din);
            check($sformatf("s1_sel%0d", i), la_sel[base+i], vt[i].e_sel);
         end
      end
      check("s1_done_once", 32'(done_cnt_a - dstart), 32'd1);
      check("s1_idle", 32'(a_busy), 32'd0);

      // Non-contiguous bytes with a partial trailing word
      base = la_addr.size(); dstart = done_cnt_a;
      a_download = 1'b1;
      cycles(1);
      send_byte(1'b0, 25'd4, 8'hAA, 1'b1);
      send_byte(1'b0, 25'd9, 8'hBB, 1'b1);
      a_download = 1'b0;
      cycles(40);
      check("s2_nreq", 32'(la_addr.size() - base), 32'd2);
      if (base + 1 < la_addr.size()) begin
         check("s2_addr0", la_addr[base], 32'd2);
         check("s2_din0_lo", la_din[base] & 32'hFF, 32'hAA);
         check("s2_sel0", la_sel[base], 32'h1);
         check("s2_addr1", la_addr[base+1], 32'd4);
         check("s2_din1_hi", (la_din[base+1] >> 8) & 32'hFF, 32'hBB);
         check("s2_sel1", la_sel[base+1], 32'h2);
      end
      check("s2_done_once", 32'(done_cnt_a - dstart), 32'd1);

      // Backpressure: acks withheld, ioctl_wait obeyed
      base = la_addr.size(); dstart = done_cnt_a;
      a_ack_en = 1'b0;
      a_download = 1'b1;
      cycles(1);
      for (int i = 0; i < 8; i++) begin
         lo = 8'(16 * i + 1); hi = 8'(16 * i + 2);
         send_byte(1'b0, 25'(128 + 2 * i), lo, 1'b1);
         send_byte(1'b0, 25'(129 + 2 * i), hi, 1'b1);
         if (i == 1) check("s3_wait_at2", 32'(a_wait), 32'd0);
         if (i == 2) begin
            check("s3_wait_at3", 32'(a_wait), 32'd1);
            a_ack_en = 1'b1;
         end
      end
      a_download = 1'b0;
      cycles(80);
      check("s3_ovf", 32'(a_ovf), 32'd0);
      check("s3_nreq", 32'(la_addr.size() - base), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (base + i < la_addr.size()) begin
            check($sformatf("s3_addr%0d", i), la_addr[base+i], 32'(64 + i));
            check($sformatf("s3_din%0d", i), la_din[base+i], {16'd0, 8'(16 * i + 2), 8'(16 * i + 1)});
         end
      end
      check("s3_done_once", 32'(done_cnt_a - dstart), 32'd1);

      // Overflow: ioctl_wait ignored, 6 words into a 4-deep FIFO with ack stalled
      base = la_addr.size();
      a_ack_en = 1'b0;
      a_download = 1'b1;
      cycles(1);
      for (int i = 0; i < 6; i++) begin
         send_byte(1'b0, 25'(512 + 2 * i), 8'(64 + 2 * i), 1'b0);
         send_byte(1'b0, 25'(513 + 2 * i), 8'(65 + 2 * i), 1'b0);
      end
      check("s4_ovf_set", 32'(a_ovf), 32'd1);
      a_ack_en = 1'b1;
      a_download = 1'b0;
      cycles(60);
      check("s4_nreq", 32'(la_addr.size() - base), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (base + i < la_addr.size()) begin
            check($sformatf("s4_addr%0d", i), la_addr[base+i], 32'(256 + i));
            check($sformatf("s4_din%0d", i), la_din[base+i], {16'd0, 8'(65 + 2 * i), 8'(64 + 2 * i)});
         end
      end
      check("s4_ovf_sticky", 32'(a_ovf), 32'd1);

      // Index filter: wrong index is ignored, rising download clears overflow
      base = la_addr.size(); dstart = done_cnt_a;
      a_index = 8'd254;
      a_download = 1'b1;
      cycles(2);
      check("f_ovf_cleared", 32'(a_ovf), 32'd0);
      send_byte(1'b0, 25'd0, 8'h55, 1'b1);
      send_byte(1'b0, 25'd1, 8'h66, 1'b1);
      a_download = 1'b0;
      cycles(20);
      check("f_nreq", 32'(la_addr.size() - base), 32'd0);
      check("f_done_once", 32'(done_cnt_a - dstart), 32'd1);
      a_index = 8'd0;

      // Reset while a request is outstanding
      a_ack_en = 1'b0;
      a_download = 1'b1;
      cycles(1);
      send_byte(1'b0, 25'd64, 8'h01, 1'b1);
      send_byte(1'b0, 25'd65, 8'h02, 1'b1);
      cycles(3);
      check("r_pending", 32'(a_req ^ a_ack), 32'd1);
      base = la_addr.size();
      a_download = 1'b0;
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      check("r_req_eq_ack", 32'(a_req), 32'(a_ack));
      check("r_busy", 32'(a_busy), 32'd0);
      check("r_wait", 32'(a_wait), 32'd0);
      a_ack_en = 1'b1;
      cycles(20);
      check("r_no_toggle", 32'(la_addr.size() - base), 32'd0);
      check("r_req_still_eq", 32'(a_req), 32'(a_ack));

      // 4-byte words, 2-deep FIFO
      base = lb_addr.size(); dstart = done_cnt_b;
      b_download = 1'b1;
      cycles(1);
      send_byte(1'b1, 25'd0, 8'hDE, 1'b1);
      send_byte(1'b1, 25'd1, 8'hAD, 1'b1);
      send_byte(1'b1, 25'd2, 8'hBE, 1'b1);
      send_byte(1'b1, 25'd3, 8'hEF, 1'b1);
      send_byte(1'b1, 25'd4, 8'h01, 1'b1);
      send_byte(1'b1, 25'd5, 8'h02, 1'b1);
      send_byte(1'b1, 25'd6, 8'h03, 1'b1);
      b_download = 1'b0;
      cycles(40);
      check("b_nreq", 32'(lb_addr.size() - base), 32'd2);
      if (base + 1 < lb_addr.size()) begin
         check("b_addr0", lb_addr[base], 32'd0);
         check("b_din0", lb_din[base], 32'hEFBEADDE);
         check("b_sel0", lb_sel[base], 32'hF);
         check("b_addr1", lb_addr[base+1], 32'd1);
         check("b_din1_low", lb_din[base+1] & 32'h00FFFFFF, 32'h00030201);
         check("b_sel1", lb_sel[base+1], 32'h7);
      end
      check("b_done_once", 32'(done_cnt_b - dstart), 32'd1);
      check("b_ovf", 32'(b_ovf), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
